// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1-style UART receiver. The asynchronous serial line is brought into the
//   i_clk domain by a two-flop synchronizer. The synchronized line is then
//   sampled at the nominal middle of every bit, and the received word is
//   presented on a parallel bus.
//
//   Handshake: o_valid is a single-cycle strobe. It rises in the same cycle
//   that o_data takes the new word. There is no ready input, so a consumer
//   must capture o_data on o_valid or later. o_data holds its value until the
//   next correctly framed word arrives. o_frame_err is a single-cycle strobe
//   for a frame whose stop bit was sampled low. It never coincides with
//   o_valid.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_rx         asynchronous serial line, idles high
//   o_data       last correctly framed word (DATA_BITS wide)
//   o_valid      one-cycle pulse when o_data is updated
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_busy       high whenever the receiver is not idle
//   o_state      current FSM state, for observation
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  // The start bit is checked half a bit in. Every later sample is taken one
  // full bit period after the previous one, so it lands mid-bit.
  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  logic half_tc, full_tc, last_bit;

  assign half_tc  = (cnt_q == HALF_TC);
  assign full_tc  = (cnt_q == FULL_TC);
  assign last_bit = (bit_q == LAST_BIT);

  // Synchronizer flops reset to the idle level. This keeps a reset release
  // from looking like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State register together with its datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rx_s_q) state_d = S_START;
      S_START:     if (half_tc) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:      if (full_tc && last_bit) state_d = S_STOP;
      S_STOP:      if (full_tc) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath next values: counters, shift register and result strobes.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      S_START: begin
        if (half_tc) begin
          cnt_d = '0;
          bit_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (full_tc) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          bit_d          = last_bit ? '0 : bit_q + BW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (full_tc) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = '0;
        bit_d = '0;
      end
    endcase
  end

  // Outputs. o_busy decodes the state directly, so it has no added latency.
  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_state     = state_q;
    o_data      = data_q;
    o_valid     = valid_q;
    o_frame_err = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int DB  = 8;
  // The start edge reaches rx_s two cycles late. Sampling happens mid-bit.
  // The result strobe is registered one cycle after the stop sample.
  localparam int LAT = ((2 * DB + 3) * CPB) / 2 + 3;

  logic          clk;
  logic          i_rst;
  logic          i_rx;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_busy;
  logic [2:0]    o_state;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc++;
    rst_at_edge = i_rst;
  end

  // ---------------- scoreboard ----------------
  // Each entry is {due_cycle[31:0], is_valid, data[7:0]}.
  logic [40:0]   exp_q[$];
  logic [DB-1:0] model_data = '0;
  logic          chk_en = 1'b0;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_valid  = 0;
  int            n_ferr   = 0;
  int            last_valid_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [40:0] cur_e;
  logic        exp_v, exp_f;
  always @(negedge clk) begin
    if (rst_at_edge) begin
      model_data = '0;
      exp_q.delete();
    end
    exp_v = 1'b0;
    exp_f = 1'b0;
    if (chk_en) begin
      if (exp_q.size() > 0 && int'(exp_q[0][40:9]) < cyc) begin
        cur_e = exp_q.pop_front();
        check("missed_event", 32'(cyc), cur_e[40:9]);
      end
      if (exp_q.size() > 0 && int'(exp_q[0][40:9]) == cyc) begin
        cur_e = exp_q.pop_front();
        if (cur_e[8]) begin
          exp_v      = 1'b1;
          model_data = cur_e[7:0];
        end else begin
          exp_f = 1'b1;
        end
      end
      check("o_valid", 32'(o_valid), 32'(exp_v));
      check("o_frame_err", 32'(o_frame_err), 32'(exp_f));
      check("o_data", 32'(o_data), 32'(model_data));
      if (o_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (o_frame_err) n_ferr++;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    exp_q.push_back({32'(start_cyc + LAT), stop_bit, data});
    i_rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < DB; b++) begin
      i_rx = data[b];
      tick(CPB);
    end
    i_rx = stop_bit;
    tick(CPB);
  endtask

  int st;
  int v0, f0;

  initial begin
    i_rst = 1'b1;
    i_rx  = 1'b1;

    // Reset values
    tick(3);
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ferr", 32'(o_frame_err), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_data", 32'(o_data), 0);
    @(posedge clk);
    #1;
    i_rst  = 1'b0;
    chk_en = 1'b1;
    tick(4);

    // Single byte 0x55, with a literal latency pin
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b1, st);
    @(negedge clk);
    check("single_count", 32'(n_valid - v0), 1);
    check("single_ferr", 32'(n_ferr - f0), 0);
    check("single_data", 32'(o_data), 32'h55);
    check("single_latency", 32'(last_valid_cyc - st), 79);
    check("single_busy_after", 32'(o_busy), 0);
    tick(5);

    // Back-to-back frames with no idle gap
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b1, st);
    send_frame(8'hFF, 1'b1, st);
    send_frame(8'hA5, 1'b1, st);
    tick(2);
    @(negedge clk);
    check("b2b_count", 32'(n_valid - v0), 3);
    check("b2b_ferr", 32'(n_ferr - f0), 0);
    check("b2b_last_data", 32'(o_data), 32'hA5);
    tick(5);

    // Glitch rejection
    v0 = n_valid; f0 = n_ferr;
    i_rx = 1'b0;
    tick(2);
    i_rx = 1'b1;
    tick(2);
    @(negedge clk);
    check("glitch_busy_high", 32'(o_busy), 1);
    tick(6);
    @(negedge clk);
    check("glitch_busy_low", 32'(o_busy), 0);
    check("glitch_no_valid", 32'(n_valid - v0), 0);
    check("glitch_no_ferr", 32'(n_ferr - f0), 0);
    tick(3);

    // Framing error followed by a break
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, st);
    tick(40);
    @(negedge clk);
    check("break_busy", 32'(o_busy), 1);
    check("break_ferr_count", 32'(n_ferr - f0), 1);
    check("break_no_valid", 32'(n_valid - v0), 0);
    check("break_data_held", 32'(o_data), 32'hA5);
    @(posedge clk);
    #1;
    i_rx = 1'b1;
    tick(4);
    @(negedge clk);
    check("break_recover_busy", 32'(o_busy), 0);
    tick(2);
    send_frame(8'h81, 1'b1, st);
    @(negedge clk);
    check("after_break_data", 32'(o_data), 32'h81);
    check("after_break_count", 32'(n_valid - v0), 1);
    tick(4);

    // Mid-frame reset during bit 3 of 0x96
    v0 = n_valid; f0 = n_ferr;
    i_rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < 3; b++) begin
      i_rx = st[0] ? 1'b1 : 1'b1; // overwritten below
      i_rx = (8'h96 >> b) & 8'h01 ? 1'b1 : 1'b0;
      tick(CPB);
    end
    i_rx = 1'b0;
    tick(CPB / 2);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    tick(2);
    i_rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(o_busy), 0);
    check("midrst_data", 32'(o_data), 0);
    @(posedge clk);
    #1;
    tick(2);
    send_frame(8'h42, 1'b1, st);
    tick(CPB);
    @(negedge clk);
    check("midrst_count", 32'(n_valid - v0), 1);
    check("midrst_ferr", 32'(n_ferr - f0), 0);
    check("midrst_data_42", 32'(o_data), 32'h42);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
